pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage MIPS pipeline. Sits beside the ID-stage decoder.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/mul_latency_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned MUL_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_MUL_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
        logic ifid_flush;
        logic mul_start;
        logic mul_busy;
        logic mul_done;
    } ctrl_t;

endpackage

// File: rtl/mul_latency_counter.sv
// Loadable down-counter timing the MADDU stall; holds at zero once reached.
module mul_latency_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for load-use, taken branch/jump and multi-cycle MADDU.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic       ex_branch_taken,
    input  logic       ex_jump,
    input  logic       ex_is_maddu,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_write,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic       ifid_flush,
    output logic       mul_start,
    output logic       mul_busy,
    output logic       mul_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   cnt_load;
    logic   cnt_zero;
    logic   load_use;

    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (idex_rt == id_rt));

    mul_latency_counter #(.W(CNT_W)) u_mul_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(MUL_LAT - 2)),
        .zero     (cnt_zero)
    );

    // Mealy decode; everything is forced low while reset is asserted.
    always_comb begin
        state_d  = state_q;
        ctrl     = '0;
        cnt_load = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.ifid_write = 1'b1;
                    ctrl.idex_write = 1'b1;
                    if (ex_is_maddu) begin
                        ctrl.pc_write     = 1'b0;
                        ctrl.ifid_write   = 1'b0;
                        ctrl.idex_write   = 1'b0;
                        ctrl.exmem_bubble = 1'b1;
                        ctrl.mul_start    = 1'b1;
                        ctrl.mul_busy     = 1'b1;
                        cnt_load          = 1'b1;
                        state_d           = ST_MUL_WAIT;
                    end else if (ex_branch_taken || ex_jump) begin
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_bubble = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_write    = 1'b0;
                        ctrl.ifid_write  = 1'b0;
                        ctrl.idex_bubble = 1'b1;
                    end
                end
                ST_MUL_WAIT: begin
                    ctrl.exmem_bubble = 1'b1;
                    ctrl.mul_busy     = 1'b1;
                    if (cnt_zero)
                        state_d = ST_MUL_DONE;
                end
                ST_MUL_DONE: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.ifid_write = 1'b1;
                    ctrl.idex_write = 1'b1;
                    ctrl.mul_done   = 1'b1;
                    state_d         = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign idex_write   = ctrl.idex_write;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_bubble = ctrl.exmem_bubble;
    assign ifid_flush   = ctrl.ifid_flush;
    assign mul_start    = ctrl.mul_start;
    assign mul_busy     = ctrl.mul_busy;
    assign mul_done     = ctrl.mul_done;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    // Saturating event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!ctrl.pc_write && (stall_q != '1))
            stall_d = stall_q + 32'd1;
        if (ctrl.ifid_flush && (flush_q != '1))
            flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
    logic       idex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_jump = 1'b0, ex_is_maddu = 1'b0;
    logic       pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble;
    logic       ifid_flush, mul_start, mul_busy, mul_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .ex_is_maddu     (ex_is_maddu),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .ifid_flush      (ifid_flush),
        .mul_start       (mul_start),
        .mul_busy        (mul_busy),
        .mul_done        (mul_done)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: stall cycles still owed to the multiplier, and a pending done cycle.
    int stall_left = 0;
    bit done_pend  = 1'b0;
    int m_stall    = 0;
    int m_flush    = 0;

    logic [8:0] dut_vec;
    assign dut_vec = {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
                      ifid_flush, mul_start, mul_busy, mul_done};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Vector order: pc, ifid, idex, idex_bubble, exmem_bubble, flush, start, busy, done.
    function automatic logic [8:0] model_out();
        bit lu;
        if (rst)                            return 9'b000_000_000;
        if (done_pend)                      return 9'b111_000_001;
        if (stall_left > 0)                 return 9'b000_010_010;
        if (ex_is_maddu)                    return 9'b000_010_110;
        if (ex_branch_taken || ex_jump)     return 9'b111_101_000;
        lu = idex_mem_read && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
        if (lu)                             return 9'b001_100_000;
        return 9'b111_000_000;
    endfunction

    task automatic model_reset();
        stall_left = 0;
        done_pend  = 1'b0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    task automatic model_advance();
        logic [8:0] e;
        e = model_out();
        if (!e[8]) m_stall++;
        if (e[3])  m_flush++;
        if (done_pend) begin
            done_pend = 1'b0;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) done_pend = 1'b1;
        end else if (ex_is_maddu) begin
            stall_left = MUL_LAT - 1;
        end
    endtask

    task automatic step(input string tag, input bit r, input logic [4:0] rs, input logic [4:0] rt,
                        input bit mr, input logic [4:0] xrt, input bit bt, input bit jp, input bit mu);
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; idex_mem_read = mr; idex_rt = xrt;
        ex_branch_taken = bt; ex_jump = jp; ex_is_maddu = mu;
        #1;
        if (rst) model_reset();
        check_eq(tag, 32'(dut_vec), 32'(model_out()));
        @(posedge clk);
        if (rst) model_reset();
        else     model_advance();
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset held with random inputs
        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        idle("post_reset", 2);

        // Load-use stall, then rt=0 never stalls
        step("load_use", 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        idle("after_lu", 1);
        step("load_use_r0", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        // Branch flush beats load-use
        step("flush_vs_lu", 1'b0, 5'd4, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        idle("after_flush", 1);

        // MADDU sequence; hazard inputs during the wait must be ignored
        step("maddu_t0", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("maddu_t1", 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        step("maddu_t2", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("maddu_t3", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("maddu_t4", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle("maddu_t5", 2);
`ifdef HAZARD_STATS_EN
        check_eq("stall_cycles_dir", stall_cycles, 32'(m_stall));
        check_eq("flush_count_dir", 32'(flush_count), 32'(m_flush));
        check_eq("stall_cycles_5", stall_cycles, 32'd5);
        check_eq("flush_count_1", 32'(flush_count), 32'd1);
`endif

        // Reset mid-MADDU aborts with no done pulse
        step("abort_t0", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("abort_t1", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        ex_is_maddu = 1'b0;
        #1;
        check_eq("abort_busy", 32'(mul_busy), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("abort_outputs", 32'(dut_vec), 32'd0);
        @(posedge clk);
        idle("abort_after", 6);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step("random", $urandom_range(0, 99) < 2,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 10);
`ifdef HAZARD_STATS_EN
            if (i % 100 == 99) begin
                check_eq("stall_cycles_rnd", stall_cycles, 32'(m_stall));
                check_eq("flush_count_rnd", 32'(flush_count), 32'(m_flush));
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
